// File: rtl/minesweeper_pkg.sv
`default_nettype none
// ============================================================================
// Module   : minesweeper_pkg
// Brief    : Shared cell-word layout and state codes for the 8x8 board array.
// Revision : 1.0 - initial release
// ============================================================================
package minesweeper_pkg;

    localparam int DEFAULT_ROWS = 8;
    localparam int DEFAULT_COLS = 8;
    localparam int CELL_W       = 7;

    localparam int NUM_MSB = 6;
    localparam int NUM_LSB = 4;
    localparam int ST_MSB  = 3;
    localparam int ST_LSB  = 1;
    localparam int BIT_POS = 0;

    typedef enum logic [2:0] {
        HIDDEN   = 3'b000,
        REVEALED = 3'b001,
        FLAG     = 3'b010,
        BOMB     = 3'b011
    } state_t;

    // Codes 3'b100..3'b111 are reserved: streamed but never tallied.
    function automatic logic is_counted(input logic [2:0] code);
        return (code[2] == 1'b0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/board_scanner.sv
`default_nettype none
// ============================================================================
// Module   : board_scanner
// Brief    : Streams the board row-major over a valid/ready link and reports
//            per-state cell counts at the end of each pass.
// Revision : 1.0 - initial release
// ============================================================================
module board_scanner
    import minesweeper_pkg::*;
#(
    parameter int ROWS  = DEFAULT_ROWS,
    parameter int COLS  = DEFAULT_COLS,
    parameter int CNT_W = 7
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [ROWS-1:0][COLS-1:0][CELL_W-1:0] board,
    input  logic                                 start,
    output logic                                 busy,
    output logic                                 cell_valid,
    input  logic                                 cell_ready,
    output logic [2:0]                           cell_row,
    output logic [2:0]                           cell_col,
    output logic [2:0]                           cell_num,
    output logic [2:0]                           cell_state,
    output logic                                 cell_bit,
    output logic                                 cell_last,
    output logic                                 done,
    output logic [CNT_W-1:0]                     hidden_cnt,
    output logic [CNT_W-1:0]                     revealed_cnt,
    output logic [CNT_W-1:0]                     flag_cnt,
    output logic [CNT_W-1:0]                     bomb_cnt
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_LOAD = 2'd1;
    localparam logic [1:0] c_SCAN = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    localparam logic [2:0] c_LAST_ROW = 3'(ROWS - 1);
    localparam logic [2:0] c_LAST_COL = 3'(COLS - 1);

    logic [1:0]              r_fsm;
    logic [2:0]              r_row;
    logic [2:0]              r_col;
    logic [CELL_W-1:0]       r_cell;
    logic                    r_valid;
    logic                    r_last;
    logic [3:0][CNT_W-1:0]   r_acc;
    logic [3:0][CNT_W-1:0]   r_cnt;

    logic                    w_accept;
    logic                    w_wrap;
    logic [2:0]              w_nrow;
    logic [2:0]              w_ncol;
    logic [2:0]              w_code;
    logic [1:0]              w_sel;
    logic [CNT_W-1:0]        w_acc_sum;
    logic [3:0][CNT_W-1:0]   w_acc_next;

    assign w_accept = (r_fsm == c_SCAN) && r_valid && cell_ready;
    assign w_wrap   = (r_col == c_LAST_COL);
    assign w_nrow   = w_wrap ? (r_row + 3'd1) : r_row;
    assign w_ncol   = w_wrap ? 3'd0 : (r_col + 3'd1);

    // One shared incrementer; the presented state code picks the accumulator.
    assign w_code    = r_cell[ST_MSB:ST_LSB];
    assign w_sel     = w_code[1:0];
    assign w_acc_sum = r_acc[w_sel] + CNT_W'(1);

    always_comb begin
        w_acc_next = r_acc;
        if (w_accept && is_counted(w_code)) begin
            w_acc_next[w_sel] = w_acc_sum;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm   <= c_IDLE;
            r_row   <= 3'd0;
            r_col   <= 3'd0;
            r_cell  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_fsm)
                c_IDLE: begin
                    if (start) begin
                        r_fsm <= c_LOAD;
                        r_row <= 3'd0;
                        r_col <= 3'd0;
                        r_acc <= '0;
                    end
                end
                c_LOAD: begin
                    r_cell  <= board[0][0];
                    r_valid <= 1'b1;
                    r_last  <= (ROWS == 1) && (COLS == 1);
                    r_fsm   <= c_SCAN;
                end
                c_SCAN: begin
                    r_acc <= w_acc_next;
                    if (w_accept) begin
                        if (r_last) begin
                            // Final cell is already folded into w_acc_next.
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_cnt   <= w_acc_next;
                            r_fsm   <= c_DONE;
                        end else begin
                            r_row  <= w_nrow;
                            r_col  <= w_ncol;
                            r_cell <= board[w_nrow][w_ncol];
                            r_last <= (w_nrow == c_LAST_ROW) && (w_ncol == c_LAST_COL);
                        end
                    end
                end
                default: begin
                    r_fsm <= c_IDLE;
                end
            endcase
        end
    end

    assign busy         = (r_fsm != c_IDLE);
    assign done         = (r_fsm == c_DONE);
    assign cell_valid   = r_valid;
    assign cell_last    = r_last;
    assign cell_row     = r_row;
    assign cell_col     = r_col;
    assign cell_num     = r_cell[NUM_MSB:NUM_LSB];
    assign cell_state   = r_cell[ST_MSB:ST_LSB];
    assign cell_bit     = r_cell[BIT_POS];

    assign hidden_cnt   = r_cnt[0];
    assign revealed_cnt = r_cnt[1];
    assign flag_cnt     = r_cnt[2];
    assign bomb_cnt     = r_cnt[3];

endmodule
`default_nettype wire

// File: tb/tb_board_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_board_scanner
// Brief    : Self-checking bench for board_scanner (table, directed, random).
// Revision : 1.0 - initial release
// ============================================================================
module tb_board_scanner;

    localparam int CNT_W = 7;

    logic                 clk;
    logic                 rst_n;
    logic [7:0][7:0][6:0] board;
    logic                 start;
    logic                 busy;
    logic                 cell_valid;
    logic                 cell_ready;
    logic [2:0]           cell_row;
    logic [2:0]           cell_col;
    logic [2:0]           cell_num;
    logic [2:0]           cell_state;
    logic                 cell_bit;
    logic                 cell_last;
    logic                 done;
    logic [CNT_W-1:0]     hidden_cnt;
    logic [CNT_W-1:0]     revealed_cnt;
    logic [CNT_W-1:0]     flag_cnt;
    logic [CNT_W-1:0]     bomb_cnt;

    board_scanner #(.ROWS(8), .COLS(8), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .board        (board),
        .start        (start),
        .busy         (busy),
        .cell_valid   (cell_valid),
        .cell_ready   (cell_ready),
        .cell_row     (cell_row),
        .cell_col     (cell_col),
        .cell_num     (cell_num),
        .cell_state   (cell_state),
        .cell_bit     (cell_bit),
        .cell_last    (cell_last),
        .done         (done),
        .hidden_cnt   (hidden_cnt),
        .revealed_cnt (revealed_cnt),
        .flag_cnt     (flag_cnt),
        .bomb_cnt     (bomb_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int last_done_cyc;
    logic [4*CNT_W-1:0] last_cnt;

    localparam int K_STRIPED  = 0;
    localparam int K_RESERVED = 1;
    localparam int K_ALLFLAG  = 2;
    localparam int R_HIGH     = 0;
    localparam int R_TOGGLE   = 1;
    localparam int R_RANDOM   = 2;

    typedef struct {
        int kind;
        int rmode;
        int h;
        int rv;
        int f;
        int b;
        int done_cyc;
    } vec_t;

    function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endfunction

    function automatic logic [4*CNT_W-1:0] dut_counts();
        return {hidden_cnt, revealed_cnt, flag_cnt, bomb_cnt};
    endfunction

    // Reference tally: count each state code across the whole board.
    function automatic logic [4*CNT_W-1:0] model_counts();
        int tally [4];
        tally = '{default: 0};
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                int code;
                code = int'(board[r][c][3:1]);
                if (code < 4) tally[code]++;
            end
        end
        return {CNT_W'(tally[0]), CNT_W'(tally[1]), CNT_W'(tally[2]), CNT_W'(tally[3])};
    endfunction

    task automatic build_board(input int kind);
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                case (kind)
                    K_STRIPED:  board[r][c] = {3'(r / 2 + 1), 3'(r / 2), 1'((r / 2) % 2)};
                    K_ALLFLAG:  board[r][c] = {3'd0, 3'd2, 1'b0};
                    K_RESERVED: board[r][c] = (r == 3 && c == 5) ? {3'd0, 3'd6, 1'b0} : 7'd0;
                    default:    board[r][c] = 7'($urandom);
                endcase
            end
        end
    endtask

    // Runs one pass from IDLE; optional spurious start pulses and a reset
    // injected when the presented cell index reaches rst_at.
    task automatic run_pass(input int rmode, input int extra_start, input int rst_at);
        int k;
        int cyc;
        int stalls;
        bit seen_done;
        logic rdy;
        logic [4*CNT_W-1:0] exp_cnt;
        logic [63:0] exp_cell;
        logic [63:0] got_cell;

        exp_cnt = model_counts();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        k = 0;
        stalls = 0;
        seen_done = 1'b0;
        check("load_busy_valid", {62'd0, busy, cell_valid}, 64'b10);
        check("cnt_hold_at_load", 64'(dut_counts()), 64'(last_cnt));

        while (cyc < 1000 && !seen_done) begin
            @(posedge clk); #1;
            cyc++;
            case (rmode)
                R_HIGH:   rdy = 1'b1;
                R_TOGGLE: rdy = 1'(cyc % 2);
                default:  rdy = ($urandom_range(0, 3) != 0);
            endcase
            cell_ready = rdy;
            start = (extra_start > 0) && (cyc == extra_start || cyc == extra_start + 30);

            if (done) begin
                seen_done = 1'b1;
                last_done_cyc = cyc;
                check("done_cycle", 64'(cyc), 64'(2 + 64 + stalls));
                check("handshakes", 64'(k), 64'd64);
                check("counts", 64'(dut_counts()), 64'(exp_cnt));
                check("done_busy_valid", {62'd0, busy, cell_valid}, 64'b10);
                last_cnt = exp_cnt;
            end else if (cell_valid) begin
                if (k == rst_at) begin
                    rst_n = 1'b0;
                    start = 1'b0;
                    #1;
                    check("rst_ctrl", {60'd0, busy, cell_valid, cell_last, done}, 64'd0);
                    check("rst_fields", {53'd0, cell_row, cell_col, cell_num, cell_state, cell_bit}, 64'd0);
                    check("rst_counts", 64'(dut_counts()), 64'd0);
                    #3;
                    rst_n = 1'b1;
                    last_cnt = '0;
                    return;
                end
                exp_cell = {49'd0, 3'(k / 8), 3'(k % 8), board[k / 8][k % 8][6:4],
                            board[k / 8][k % 8][3:1], board[k / 8][k % 8][0], 1'(k == 63)};
                got_cell = {49'd0, cell_row, cell_col, cell_num, cell_state, cell_bit, cell_last};
                check($sformatf("cell%0d", k), got_cell, exp_cell);
                if (rdy) k++;
                else stalls++;
            end else begin
                check("scan_bubble", 64'(cell_valid), 64'd1);
            end
        end
        start = 1'b0;
        if (!seen_done) begin
            check("done_timeout", 64'd0, 64'd1);
        end else begin
            @(posedge clk); #1;
            check("idle_after_done", {61'd0, busy, cell_valid, done}, 64'd0);
            check("cnt_hold_after", 64'(dut_counts()), 64'(last_cnt));
        end
    endtask

    vec_t vecs [4];

    initial begin
        vecs[0] = '{K_STRIPED,  R_TOGGLE, 16, 16, 16, 16, 130};
        vecs[1] = '{K_STRIPED,  R_HIGH,   16, 16, 16, 16,  66};
        vecs[2] = '{K_ALLFLAG,  R_HIGH,    0,  0, 64,  0,  66};
        vecs[3] = '{K_RESERVED, R_HIGH,   63,  0,  0,  0,  66};

        rst_n = 1'b0;
        start = 1'b0;
        cell_ready = 1'b0;
        last_cnt = '0;
        last_done_cyc = 0;
        build_board(K_STRIPED);
        @(posedge clk); #2;
        check("reset_ctrl", {60'd0, busy, cell_valid, cell_last, done}, 64'd0);
        check("reset_fields", {53'd0, cell_row, cell_col, cell_num, cell_state, cell_bit}, 64'd0);
        check("reset_counts", 64'(dut_counts()), 64'd0);
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table passes run back to back: each starts in the IDLE cycle after the previous DONE.
        for (int i = 0; i < 4; i++) begin
            build_board(vecs[i].kind);
            run_pass(vecs[i].rmode, 0, -1);
            check($sformatf("vec%0d_done_cyc", i), 64'(last_done_cyc), 64'(vecs[i].done_cyc));
            check($sformatf("vec%0d_counts", i), 64'(dut_counts()),
                  64'({CNT_W'(vecs[i].h), CNT_W'(vecs[i].rv), CNT_W'(vecs[i].f), CNT_W'(vecs[i].b)}));
        end

        // Start pulsed twice mid-scan must be ignored.
        build_board(K_STRIPED);
        run_pass(R_HIGH, 10, -1);
        check("spurious_start_done_cyc", 64'(last_done_cyc), 64'd66);
        repeat (3) begin
            @(posedge clk); #1;
            check("no_second_pass", {62'd0, busy, done}, 64'd0);
        end

        // Reset at cell 20, then a clean full pass.
        run_pass(R_TOGGLE, 0, 20);
        run_pass(R_HIGH, 0, -1);
        check("post_reset_counts", 64'(dut_counts()), 64'({4{CNT_W'(16)}}));

        // Random boards (including reserved codes) with random back-pressure.
        for (int p = 0; p < 6; p++) begin
            build_board(99);
            run_pass(R_RANDOM, 0, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
